sram_march_bist: RTL and testbench

//   Parametrised March-test BIST controller for a single-port synchronous SRAM. Successor to the

---
 rtl/sram_march_bist.sv | 194 +++++++++++++++++++
 tb/tb_sram_march_bist.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_march_bist.sv
// March-test BIST controller for a single-port synchronous SRAM: MATS+, March X or March C-,
// solid or checkerboard background, first-fail capture and a saturating miscompare counter.
module sram_march_bist #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        alg_sel,
    input  logic              bg_sel,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  fail_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    typedef struct packed {
        logic down;
        logic two;
    } elem_ctl_t;

    // Element direction and op count; alg[1] set selects March C-.
    function automatic elem_ctl_t elem_ctl(input logic [1:0] alg, input logic [2:0] elem);
        elem_ctl_t c;
        c.down = 1'b0;
        c.two  = 1'b0;
        case (elem)
            3'd1: c.two = 1'b1;
            3'd2: begin c.two = 1'b1; c.down = ~alg[1]; end
            3'd3: begin c.two = alg[1]; c.down = alg[1]; end
            3'd4: begin c.two = 1'b1; c.down = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] last_elem(input logic [1:0] alg);
        case (alg)
            2'd0:    return 3'd2;
            2'd1:    return 3'd3;
            default: return 3'd5;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] bg_word(input logic cb);
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W; i++) w[i] = cb & (i % 2 == 0);
        return w;
    endfunction

    state_t            state, state_n;
    logic [1:0]        alg_q, alg_n;
    logic              bg_q, bg_n;
    logic [2:0]        elem_q, elem_n;
    logic              op_q, op_n;
    logic [ADDR_W-1:0] addr_n;
    logic              issue, advance, clear;
    elem_ctl_t         cur, ctl_n;
    logic              op_we, op_v;
    logic [DATA_W-1:0] word_n, exp_q, cmp_exp;
    logic [ADDR_W-1:0] cmp_addr;
    logic              cmp_valid, miscmp;
    logic [CNT_W-1:0]  fail_count_n;

    // Sequencer: picks the op to drive next cycle and the compare bookkeeping.
    always_comb begin
        state_n = state;
        alg_n   = alg_q;
        bg_n    = bg_q;
        elem_n  = elem_q;
        op_n    = op_q;
        addr_n  = mem_addr;
        issue   = 1'b0;
        advance = 1'b0;
        clear   = 1'b0;
        cur     = elem_ctl(alg_q, elem_q);
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n = S_RUN;
                    alg_n   = alg_sel;
                    bg_n    = bg_sel;
                    elem_n  = '0;
                    op_n    = 1'b0;
                    issue   = 1'b1;
                    advance = 1'b1;
                    clear   = 1'b1;
                end
            end
            S_RUN: begin
                issue = 1'b1;
                if (cur.two && !op_q) begin
                    op_n = 1'b1;
                end else begin
                    op_n = 1'b0;
                    if (mem_addr == (cur.down ? '0 : ADDR_MAX)) begin
                        if (elem_q == last_elem(alg_q)) begin
                            state_n = S_DRAIN;
                            issue   = 1'b0;
                        end else begin
                            elem_n  = elem_q + 3'd1;
                            advance = 1'b1;
                        end
                    end else if (cur.down) begin
                        addr_n = mem_addr - ADDR_W'(1);
                    end else begin
                        addr_n = mem_addr + ADDR_W'(1);
                    end
                end
            end
            S_DRAIN: state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
        ctl_n = elem_ctl(alg_n, elem_n);
        if (advance) addr_n = ctl_n.down ? ADDR_MAX : '0;
        // Two-op elements alternate polarity: odd elements r0,w1; even elements r1,w0.
        op_we  = ctl_n.two ? op_n : (elem_n == 3'd0);
        op_v   = ctl_n.two & (op_n ^ ~elem_n[0]);
        word_n = op_v ? ~bg_word(bg_n) : bg_word(bg_n);
        miscmp = cmp_valid && (mem_rdata != cmp_exp);
        fail_count_n = (miscmp && fail_count != CNT_MAX) ? fail_count + CNT_W'(1) : fail_count;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            alg_q      <= '0;
            bg_q       <= 1'b0;
            elem_q     <= '0;
            op_q       <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            exp_q      <= '0;
            cmp_valid  <= 1'b0;
            cmp_exp    <= '0;
            cmp_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_count <= '0;
            fail_addr  <= '0;
            fail_exp   <= '0;
            fail_got   <= '0;
        end else begin
            state     <= state_n;
            alg_q     <= alg_n;
            bg_q      <= bg_n;
            elem_q    <= elem_n;
            op_q      <= op_n;
            mem_en    <= issue;
            mem_we    <= issue & op_we;
            mem_addr  <= addr_n;
            mem_wdata <= (issue && op_we) ? word_n : '0;
            exp_q     <= word_n;
            cmp_valid <= mem_en & ~mem_we;
            cmp_exp   <= exp_q;
            cmp_addr  <= mem_addr;
            busy      <= (state_n == S_RUN) || (state_n == S_DRAIN);
            done      <= (state_n == S_DONE);
            if (clear) begin
                pass       <= 1'b0;
                fail_count <= '0;
                fail_addr  <= '0;
                fail_exp   <= '0;
                fail_got   <= '0;
            end else begin
                fail_count <= fail_count_n;
                pass       <= (state_n == S_DONE) && (fail_count_n == '0);
                if (miscmp && fail_count == '0) begin
                    fail_addr <= cmp_addr;
                    fail_exp  <= cmp_exp;
                    fail_got  <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: ideal 1-cycle SRAM with an optional bit0 stuck-at-1 cell at address 5,
// expected run results queued at start and compared when done rises.
module tb_sram_march_bist;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned N      = 16;

    logic              clk = 1'b0;
    logic              rst_n, start, bg_sel;
    logic [1:0]        alg_sel;
    logic              mem_en, mem_we, busy, done, pass;
    logic [ADDR_W-1:0] mem_addr, fail_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata, fail_exp, fail_got;
    logic [CNT_W-1:0]  fail_count;

    sram_march_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alg_sel(alg_sel), .bg_sel(bg_sel),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
        .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [N];
    logic              fault_on;
    logic [DATA_W-1:0] rd;
    int                op_total = 0;
    int                wd_bad   = 0;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
            end else begin
                rd = mem[mem_addr];
                if (fault_on && mem_addr == 4'd5) rd[0] = 1'b1;
                mem_rdata <= rd;
            end
        end
    end

    always @(posedge clk) begin
        if (mem_en) op_total++;
        if (!(mem_en && mem_we) && mem_wdata != '0) wd_bad++;
    end

    typedef struct {
        int                edges;
        int                ops;
        logic              pass;
        logic [CNT_W-1:0]  cnt;
        logic [ADDR_W-1:0] fa;
        logic [DATA_W-1:0] fe;
        logic [DATA_W-1:0] fg;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] alg, input logic p, input int cnt,
                            input int fa, input int fe, input int fg);
        exp_t e;
        int   k;
        k       = (alg == 2'd0) ? 5 : (alg == 2'd1) ? 6 : 10;
        e.edges = k * N + 1;
        e.ops   = k * N;
        e.pass  = p;
        e.cnt   = CNT_W'(cnt);
        e.fa    = ADDR_W'(fa);
        e.fe    = DATA_W'(fe);
        e.fg    = DATA_W'(fg);
        sb.push_back(e);
    endtask

    task automatic run(input logic [1:0] alg, input logic bg, input int glitch_at);
        exp_t e;
        int   n;
        int   ops0;
        int   busy_bad;
        @(negedge clk);
        alg_sel = alg;
        bg_sel  = bg;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        alg_sel = ~alg;
        bg_sel  = ~bg;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_done_clr", 32'(done), 32'd0);
        chk("start_cnt_clr", 32'(fail_count), 32'd0);
        chk("start_addr_clr", 32'(fail_addr), 32'd0);
        ops0     = op_total;
        n        = 0;
        busy_bad = 0;
        while (!done && n < 400) begin
            if (n == glitch_at - 1) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (!done && !busy) busy_bad++;
        end
        if (sb.size() == 0) begin
            $display("FAIL scoreboard: observed empty queue expected entry");
            $fatal(1);
        end
        e = sb.pop_front();
        chk("done_edge", 32'(n), 32'(e.edges));
        chk("op_count", 32'(op_total - ops0), 32'(e.ops));
        chk("busy_during_run", 32'(busy_bad), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("mem_en_after", 32'(mem_en), 32'd0);
        chk("pass", 32'(pass), 32'(e.pass));
        chk("fail_count", 32'(fail_count), 32'(e.cnt));
        chk("fail_addr", 32'(fail_addr), 32'(e.fa));
        chk("fail_exp", 32'(fail_exp), 32'(e.fe));
        chk("fail_got", 32'(fail_got), 32'(e.fg));
        chk("wdata_idle_zero", 32'(wd_bad), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        alg_sel  = 2'd0;
        bg_sel   = 1'b0;
        fault_on = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_fail_count", 32'(fail_count), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fault-free runs of every algorithm and background
        push_exp(2'd2, 1'b1, 0, 0, 0, 0);
        run(2'd2, 1'b0, 0);
        push_exp(2'd0, 1'b1, 0, 0, 0, 0);
        run(2'd0, 1'b0, 0);
        push_exp(2'd1, 1'b1, 0, 0, 0, 0);
        run(2'd1, 1'b1, 0);
        push_exp(2'd3, 1'b1, 0, 0, 0, 0);
        run(2'd3, 1'b1, 0);

        // Stuck-at-1 on bit0 of address 5
        fault_on = 1'b1;
        push_exp(2'd2, 1'b0, 3, 5, 8'h00, 8'h01);
        run(2'd2, 1'b0, 0);
        push_exp(2'd2, 1'b0, 2, 5, 8'hAA, 8'hAB);
        run(2'd2, 1'b1, 0);
        push_exp(2'd0, 1'b0, 1, 5, 8'h00, 8'h01);
        run(2'd0, 1'b0, 0);

        // Start during a run is ignored; then restart from DONE with the fault removed
        push_exp(2'd2, 1'b0, 3, 5, 8'h00, 8'h01);
        run(2'd2, 1'b0, 20);
        fault_on = 1'b0;
        push_exp(2'd2, 1'b1, 0, 0, 0, 0);
        run(2'd2, 1'b0, 0);

        // Reset at edge 50 of a faulty run
        fault_on = 1'b1;
        @(negedge clk);
        alg_sel = 2'd2;
        bg_sel  = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_fail_count", 32'(fail_count), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_mem_en", 32'(mem_en), 32'd0);
        chk("mid_rst_mem_we", 32'(mem_we), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_fail_count", 32'(fail_count), 32'd0);
        chk("mid_rst_fail_addr", 32'(fail_addr), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        fault_on = 1'b0;
        push_exp(2'd2, 1'b1, 0, 0, 0, 0);
        run(2'd2, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
